// File: rtl/vision_cls_pkg.sv
// Shared types and result encodings for the vision classifier slice.
package vision_cls_pkg;

  // Result encodings; users slice RES_REJECT down to their own id width.
  localparam logic [31:0] RES_NONE   = '0;
  localparam logic [31:0] RES_REJECT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/min_fold_unit.sv
// Folds one class minimum into the running best (and runner-up with ARGMIN_MARGIN_EN).
module min_fold_unit #(
  parameter int ADDW = 14,
  parameter int IDW  = 3
) (
  input  logic [ADDW-1:0] cand,
  input  logic [IDW-1:0]  cand_id,
  input  logic [ADDW-1:0] best,
  input  logic [IDW-1:0]  best_id,
`ifdef ARGMIN_MARGIN_EN
  input  logic [ADDW-1:0] runner,
  output logic [ADDW-1:0] new_runner,
`endif
  output logic [ADDW-1:0] new_best,
  output logic [IDW-1:0]  new_best_id
);

  // Strict less-than keeps the earlier (lower id) class on a tie.
  always_comb begin
    new_best    = best;
    new_best_id = best_id;
`ifdef ARGMIN_MARGIN_EN
    new_runner  = runner;
`endif
    if (cand < best) begin
      new_best    = cand;
      new_best_id = cand_id;
`ifdef ARGMIN_MARGIN_EN
      new_runner  = best;
    end else if (cand < runner) begin
      new_runner  = cand;
`endif
    end
  end

endmodule

// File: rtl/argmin_class_seq.sv
// Sequential argmin classifier: scans a CLAS x MODI count snapshot one entry per cycle.
// Optional reject margin enabled by defining ARGMIN_MARGIN_EN.
module argmin_class_seq
  import vision_cls_pkg::*;
#(
  parameter int CLAS = 5,
  parameter int MODI = 6,
  parameter int ADDW = 14,
  parameter int IDW  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     start,
  input  logic [CLAS*MODI*ADDW-1:0] cnt_bus,
  input  logic [ADDW-1:0]          th,
`ifdef ARGMIN_MARGIN_EN
  input  logic [ADDW-1:0]          mth,
  output logic [ADDW-1:0]          margin,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [IDW-1:0]           res,
  output logic [ADDW-1:0]          min_val
);

  localparam int MODN = CLAS * MODI;
  localparam int MW   = (MODI > 1) ? $clog2(MODI) : 1;
  localparam logic [MW-1:0]  MOD_LAST = MW'(MODI - 1);
  localparam logic [IDW-1:0] CLS_LAST = IDW'(CLAS);
  localparam logic [IDW-1:0] RES_REJ  = IDW'(RES_REJECT);
  localparam logic [IDW-1:0] RES_NIL  = IDW'(RES_NONE);

  if (CLAS + 1 >= 2**IDW) begin : g_idw_check
    $error("argmin_class_seq: IDW too small for CLAS plus reject code");
  end

  fsm_state_t state_q, state_d;

  logic [MODN*ADDW-1:0] snap_q;
  logic [ADDW-1:0]      th_q;
  logic [MW-1:0]        mod_q;
  logic [IDW-1:0]       cls_q;
  logic [ADDW-1:0]      cls_min_q;
  logic [ADDW-1:0]      best_q;
  logic [IDW-1:0]       best_id_q;
  logic [IDW-1:0]       res_q;
  logic [ADDW-1:0]      min_val_q;

  logic [ADDW-1:0]      entry;
  logic [ADDW-1:0]      cand;
  logic                 last_mod;
  logic                 last_entry;
  logic [ADDW-1:0]      fold_best;
  logic [IDW-1:0]       fold_id;
  logic                 accept;

`ifdef ARGMIN_MARGIN_EN
  logic [ADDW-1:0]      mth_q;
  logic [ADDW-1:0]      runner_q;
  logic [ADDW-1:0]      fold_runner;
  logic [ADDW-1:0]      margin_q;
  logic [ADDW-1:0]      margin_w;
`endif

  // The snapshot shifts down each cycle, so the current entry is always the low slice.
  assign entry      = snap_q[ADDW-1:0];
  assign cand       = (entry < cls_min_q) ? entry : cls_min_q;
  assign last_mod   = (mod_q == MOD_LAST);
  assign last_entry = last_mod && (cls_q == CLS_LAST);

  min_fold_unit #(
    .ADDW (ADDW),
    .IDW  (IDW)
  ) u_fold (
    .cand        (cand),
    .cand_id     (cls_q),
    .best        (best_q),
    .best_id     (best_id_q),
`ifdef ARGMIN_MARGIN_EN
    .runner      (runner_q),
    .new_runner  (fold_runner),
`endif
    .new_best    (fold_best),
    .new_best_id (fold_id)
  );

`ifdef ARGMIN_MARGIN_EN
  assign margin_w = fold_runner - fold_best;
  assign accept   = (fold_best < th_q) && !(margin_w < mth_q);
  assign margin   = margin_q;
`else
  assign accept   = (fold_best < th_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = SCAN;
        SCAN:    if (last_entry) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Result registers load on the last scan edge so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q    <= '0;
      th_q      <= '0;
      mod_q     <= '0;
      cls_q     <= '0;
      cls_min_q <= '1;
      best_q    <= '1;
      best_id_q <= '0;
      res_q     <= RES_NIL;
      min_val_q <= '0;
`ifdef ARGMIN_MARGIN_EN
      mth_q     <= '0;
      runner_q  <= '1;
      margin_q  <= '0;
`endif
    end else if (clr) begin
      res_q     <= RES_NIL;
      min_val_q <= '0;
`ifdef ARGMIN_MARGIN_EN
      margin_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            snap_q    <= cnt_bus;
            th_q      <= th;
            mod_q     <= '0;
            cls_q     <= IDW'(1);
            cls_min_q <= '1;
            best_q    <= '1;
            best_id_q <= '0;
`ifdef ARGMIN_MARGIN_EN
            mth_q     <= mth;
            runner_q  <= '1;
`endif
          end
        end
        SCAN: begin
          snap_q <= snap_q >> ADDW;
          if (last_mod) begin
            mod_q     <= '0;
            cls_q     <= cls_q + IDW'(1);
            cls_min_q <= '1;
            best_q    <= fold_best;
            best_id_q <= fold_id;
`ifdef ARGMIN_MARGIN_EN
            runner_q  <= fold_runner;
`endif
            if (last_entry) begin
              res_q     <= accept ? fold_id : RES_REJ;
              min_val_q <= fold_best;
`ifdef ARGMIN_MARGIN_EN
              margin_q  <= margin_w;
`endif
            end
          end else begin
            mod_q     <= mod_q + MW'(1);
            cls_min_q <= cand;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q == SCAN);
  assign done    = (state_q == FIN);
  assign res     = res_q;
  assign min_val = min_val_q;

endmodule

// File: tb/tb_argmin_class_seq.sv
// Directed self-checking bench for argmin_class_seq (default parameters).
module tb_argmin_class_seq;

  localparam int CLAS = 5;
  localparam int MODI = 6;
  localparam int ADDW = 14;
  localparam int IDW  = 3;
  localparam int MODN = CLAS * MODI;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic                 start = 1'b0;
  logic [MODN*ADDW-1:0] cnt_bus = '0;
  logic [ADDW-1:0]      th = '0;
  logic                 busy;
  logic                 done;
  logic [IDW-1:0]       res;
  logic [ADDW-1:0]      min_val;
`ifdef ARGMIN_MARGIN_EN
  logic [ADDW-1:0]      mth = '0;
  logic [ADDW-1:0]      margin;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  argmin_class_seq #(
    .CLAS (CLAS),
    .MODI (MODI),
    .ADDW (ADDW),
    .IDW  (IDW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .start   (start),
    .cnt_bus (cnt_bus),
    .th      (th),
`ifdef ARGMIN_MARGIN_EN
    .mth     (mth),
    .margin  (margin),
`endif
    .busy    (busy),
    .done    (done),
    .res     (res),
    .min_val (min_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [ADDW-1:0] v);
    for (int k = 0; k < MODN; k++) cnt_bus[k*ADDW +: ADDW] = v;
  endtask

  // c is the 1-based class id, m the mode index.
  task automatic set_entry(input int c, input int m, input logic [ADDW-1:0] v);
    cnt_bus[((c - 1) * MODI + m) * ADDW +: ADDW] = v;
  endtask

  // Pulses start for one edge, waits (bounded) for done, checks latency/busy/result.
  task automatic run_scan(input string tag, input logic [31:0] exp_res, input logic [31:0] exp_min);
    int unsigned lat = 0;
    bit busy_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, lat, MODN + 1);
    chk({tag, "_busy_during_scan"}, busy_ok, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_min_val"}, min_val, exp_min);
  endtask

  int unsigned n_done;

  initial begin
    #12;
    chk("reset_res", res, 0);
    chk("reset_min_val", min_val, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;

    // Single winning entry at class 3 mode 2.
    th = 14'd2000;
    set_all(14'd3000);
    set_entry(3, 2, 14'd500);
    run_scan("basic", 3, 500);
    @(posedge clk); #1;
    chk("hold_done_low", done, 0);
    chk("hold_res", res, 3);

    set_all(14'd3000);
    run_scan("all_above_th", 7, 3000);

    set_all(14'd2000);
    run_scan("best_eq_th", 7, 2000);

    // Tie between classes 2 and 4: lower id wins.
    set_all(14'd900);
    set_entry(2, 5, 14'd100);
    set_entry(4, 0, 14'd100);
    run_scan("tie", 2, 100);

    set_all('1);
    th = '1;
    run_scan("all_ones", 7, 16383);

    // Restore a known result, then abort a scan with clr at T+10.
    th = 14'd2000;
    set_all(14'd900);
    set_entry(2, 5, 14'd100);
    run_scan("pre_clr", 2, 100);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_res", res, 0);
    chk("clr_min_val", min_val, 0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    chk("clr_no_done", n_done, 0);

    // start and clr together stay idle.
    start = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clr = 1'b0;
    chk("start_clr_busy", busy, 0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) n_done++;
      @(posedge clk); #1;
    end
    chk("start_clr_idle", n_done, 0);

    // Snapshot: inputs change and start repeats mid-scan.
    th = 14'd2000;
    set_all(14'd3000);
    set_entry(5, 5, 14'd42);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 75; k++) begin
      if (k == 5) begin
        set_all(14'd10);
        set_entry(1, 0, 14'd1);
        th = 14'd5;
      end
      start = (k == 10);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          chk("snap_latency", k, MODN + 1);
          chk("snap_res", res, 5);
          chk("snap_min_val", min_val, 42);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("snap_single_done", n_done, 1);

`ifdef ARGMIN_MARGIN_EN
    th = 14'd2000;
    set_all(14'd900);
    set_entry(1, 3, 14'd100);
    set_entry(2, 1, 14'd150);
    mth = 14'd100;
    run_scan("margin_rej", 7, 100);
    chk("margin_val_rej", margin, 50);
    mth = 14'd40;
    run_scan("margin_ok", 1, 100);
    chk("margin_val_ok", margin, 50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
